// File: rtl/cpu_types.sv
// Shared CPU-side types and constants used by the memory arbiter.
package cpu_types;

  // Response pipeline state: which port (if any) gets a response this cycle.
  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_I,
    RESP_D
  } mem_resp_state_t;

  // Consecutive data grants tolerated while a fetch is waiting.
  localparam int MEM_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Data side wins contention; a streak counter forces a fetch grant after
// STARVE_LIMIT consecutive data wins. Responses return one cycle after grant.
module mem_arbiter
  import cpu_types::*;
#(
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_gnt,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic        dmem_gnt,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rd
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  mem_resp_state_t state_reg, state_next;
  logic [3:0]      streak_reg, streak_next;
  logic [31:0]     rdata_reg;
  logic            grant_i, grant_d;

  // Grant selection: data first unless the fetch has waited LIMIT data grants.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (dmem_req && !(imem_req && (streak_reg == LIMIT))) begin
        grant_d = 1'b1;
      end else if (imem_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Streak counter: counts data wins over a waiting fetch, saturating at LIMIT.
  always_comb begin
    streak_next = streak_reg;
    if (!imem_req || grant_i) begin
      streak_next = 4'd0;
    end else if (grant_d && (streak_reg != LIMIT)) begin
      streak_next = streak_reg + 4'd1;
    end
  end

  // Response FSM next state: remember which port was granted this cycle.
  always_comb begin
    state_next = RESP_IDLE;
    if (grant_i) begin
      state_next = RESP_I;
    end else if (grant_d) begin
      state_next = RESP_D;
    end
  end

  // State, streak and captured read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RESP_IDLE;
      streak_reg <= 4'd0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      if (grant_i || grant_d) begin
        rdata_reg <= ram_rd;
      end
    end
  end

  assign imem_gnt = grant_i;
  assign dmem_gnt = grant_d;

  // A response pending when reset arrives is dropped immediately.
  assign imem_rvalid = (state_reg == RESP_I) && !rst;
  assign dmem_rvalid = (state_reg == RESP_D) && !rst;
  assign imem_rdata  = rdata_reg;
  assign dmem_rdata  = rdata_reg;

  // With no grant the RAM address idles on the fetch address.
  assign ram_a  = grant_d ? dmem_addr : imem_addr;
  assign ram_wd = dmem_wdata;
  assign ram_be = dmem_be;
  assign ram_we = grant_d & dmem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven vectors plus directed
// contention and reset sequences, with a response scoreboard queue.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        ram_we;
  logic [31:0] ram_a;
  logic [31:0] ram_wd;
  logic [3:0]  ram_be;
  logic [31:0] ram_rd;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_be(ram_be),
    .ram_rd(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, byte-enabled write on the clock edge.
  logic [31:0] ram_mem [0:255];
  assign ram_rd = ram_mem[ram_a[9:2]];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) ram_mem[ram_a[9:2]][b*8 +: 8] <= ram_wd[b*8 +: 8];
      end
    end
  end

  // Reference memory maintained by the bench from the stimulus it drives.
  logic [31:0] ref_mem [0:255];

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_ig;
    logic        exp_dg;
  } vec_t;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  vec_t  tbl [13];
  int    vec_no = 0;

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic eig, input logic edg);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw;
    v.daddr = da; v.wdata = wd; v.be = be; v.exp_ig = eig; v.exp_dg = edg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check last cycle's response, check grants.
  task automatic run_vec(input vec_t v);
    resp_t       r;
    logic [31:0] old_word;
    logic [31:0] exp_a;
    @(posedge clk);
    #1;
    rst        = v.rst;
    imem_req   = v.ireq;
    imem_addr  = v.iaddr;
    dmem_req   = v.dreq;
    dmem_we    = v.dwe;
    dmem_addr  = v.daddr;
    dmem_wdata = v.wdata;
    dmem_be    = v.be;
    #3;
    // Response due from the previous cycle's grant.
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (v.rst) begin
        chk("dropped_imem_rvalid", {31'd0, imem_rvalid}, 32'd0);
        chk("dropped_dmem_rvalid", {31'd0, dmem_rvalid}, 32'd0);
      end else begin
        chk("imem_rvalid", {31'd0, imem_rvalid}, {31'd0, r.is_i});
        chk("dmem_rvalid", {31'd0, dmem_rvalid}, {31'd0, !r.is_i});
        chk("rdata", r.is_i ? imem_rdata : dmem_rdata, r.data);
      end
    end else begin
      chk("idle_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
    end
    // Grants and RAM drive for this cycle.
    chk("imem_gnt", {31'd0, imem_gnt}, {31'd0, v.exp_ig});
    chk("dmem_gnt", {31'd0, dmem_gnt}, {31'd0, v.exp_dg});
    chk("ram_we", {31'd0, ram_we}, {31'd0, v.exp_dg & v.dwe});
    exp_a = v.exp_dg ? v.daddr : v.iaddr;
    chk("ram_a", ram_a, exp_a);
    if (v.exp_dg) begin
      chk("ram_wd", ram_wd, v.wdata);
      chk("ram_be", {28'd0, ram_be}, {28'd0, v.be});
    end
    if (!v.rst && (v.exp_ig || v.exp_dg)) begin
      old_word = ref_mem[exp_a[9:2]];
      r.is_i = v.exp_ig;
      r.data = old_word;
      exp_q.push_back(r);
      if (v.exp_dg && v.dwe) begin
        for (int b = 0; b < 4; b++) begin
          if (v.be[b]) ref_mem[exp_a[9:2]][b*8 +: 8] = v.wdata[b*8 +: 8];
        end
      end
    end
    $display("vec %0d rst=%0b ireq=%0b dreq=%0b we=%0b ig=%0b dg=%0b ram_a=%h irv=%0b drv=%0b",
             vec_no, v.rst, v.ireq, v.dreq, v.dwe, imem_gnt, dmem_gnt, ram_a,
             imem_rvalid, dmem_rvalid);
    vec_no++;
  endtask

  vec_t idle_v;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hA5000000 | 32'(i);
    end
    ram_mem[4]   = 32'h00500093;
    ram_mem[64]  = 32'h11223344;
    ram_mem[128] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];

    rst = 1'b1; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_we = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_be = '0;
    idle_v = mk(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);

    // Vector table: requests in, expected grants out.
    tbl[0]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0);
    tbl[1]  = mk(0, 1, 32'h10,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0);
    tbl[2]  = mk(0, 0, 32'h0,   0, 1, 32'h100, 32'h12345678, 4'hF, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,   1, 1, 32'h100, 32'hAABBCCDD, 4'h3, 0, 1);
    tbl[4]  = mk(0, 0, 32'h0,   1, 0, 32'h100, 32'h0,        4'hF, 0, 1);
    tbl[5]  = mk(0, 0, 32'h0,   1, 1, 32'h200, 32'h01020304, 4'h0, 0, 1);
    tbl[6]  = mk(0, 0, 32'h0,   1, 0, 32'h200, 32'h0,        4'h0, 0, 1);
    tbl[7]  = mk(0, 1, 32'h14,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0);
    tbl[8]  = mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 0, 0);
    tbl[9]  = mk(0, 1, 32'h18,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0);
    tbl[10] = mk(0, 1, 32'h1C,  1, 0, 32'h20,  32'h0,        4'h0, 0, 1);
    tbl[11] = mk(0, 1, 32'h1C,  0, 0, 32'h0,   32'h0,        4'h0, 1, 0);
    tbl[12] = mk(0, 0, 32'h0,   1, 0, 32'h24,  32'h0,        4'h0, 0, 1);

    // Reset with both requests high: no grants, no write, no rvalid.
    run_vec(mk(1, 1, 32'h10, 1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0));
    run_vec(mk(1, 1, 32'h10, 1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0));
    run_vec(idle_v);
    chk("reset_rdata", dmem_rdata, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);
    run_vec(idle_v);
    chk("partial_store_word", ram_mem[64], 32'h1122CCDD);
    chk("zero_be_word", ram_mem[128], 32'hDEADBEEF);

    // Contention: D,D,D,D,I repeating for 12 cycles.
    for (int c = 0; c < 12; c++) begin
      logic is_i;
      is_i = ((c % 5) == 4);
      run_vec(mk(0, 1, 32'h10, 1, 0, 32'h20, 32'h0, 4'h0, is_i, !is_i));
    end
    run_vec(idle_v);

    // imem_req toggling alone must leave the streak at zero: a fresh
    // contention run still grants four data accesses before the fetch.
    for (int c = 0; c < 4; c++) begin
      run_vec(mk(0, c[0], 32'h30, 0, 0, 32'h0, 32'h0, 4'h0, c[0], 0));
    end
    run_vec(idle_v);
    for (int c = 0; c < 5; c++) begin
      run_vec(mk(0, 1, 32'h34, 1, 0, 32'h28, 32'h0, 4'h0, c == 4, c != 4));
    end
    run_vec(idle_v);

    // Reset mid-response: load granted, then rst with a store that must not land.
    run_vec(mk(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 1));
    run_vec(mk(1, 0, 32'h0, 1, 1, 32'h100, 32'h99999999, 4'hF, 0, 0));
    run_vec(idle_v);
    chk("mid_reset_rdata", imem_rdata, 32'd0);
    run_vec(mk(0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 1));
    run_vec(idle_v);
    chk("post_reset_load", dmem_rdata, 32'h1122CCDD);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
